simd_mem_arbiter: RTL and testbench

Round-robin arbiter and burst sequencer for the single-port data memory shared by the SIMD datapath. It sits between the memory macro and its requesters: requester 0 is the load fetch unit (matrix A/B reads into the PEs), requester 1 is the store unit (PE result write-back), and requester 2 is the optional host/debug port. It grants one whole burst at a time. It generates auto-incrementing addresses and returns per-beat strobes and a completion pulse, so the control unit's LOAD/STORE states only have to wait for DONE.

---
 rtl/simd_mem_arbiter_pkg.sv | 32 +++
 rtl/simd_mem_arbiter_if.sv | 33 +++
 rtl/simd_mem_arbiter_rr_pick.sv | 31 +++
 rtl/simd_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_simd_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simd_mem_arbiter_pkg.sv
// Shared widths, requester indices and FSM state type for the SIMD data-memory arbiter.
// SIMD_MEM_ARB_HOST_EN adds the host/debug requester (index 2) to the round-robin.
package simd_mem_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  localparam int REQ_LOAD  = 0;
  localparam int REQ_STORE = 1;
  localparam int REQ_HOST  = 2;

`ifdef SIMD_MEM_ARB_HOST_EN
  localparam int NREQ = 3;
`else
  localparam int NREQ = 2;
`endif

  localparam int PTR_W = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_FINISH
  } state_e;

  // Round-robin pointer after granting idx: one past the winner, wrapping at NREQ.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    return (int'(idx) >= NREQ - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/simd_mem_arbiter_if.sv
// Requester and memory-macro bus of the SIMD data-memory arbiter.
// master = requesters plus memory macro; slave = the arbiter itself.
interface simd_mem_arbiter_if;
  import simd_mem_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*LEN_W-1:0]  len;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        beat;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic [NREQ-1:0]        done;

  logic                   mem_en;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport master (
    output req, we, addr, len, wdata, mem_rdata,
    input  gnt, beat, rvalid, rdata, done, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, addr, len, wdata, mem_rdata,
    output gnt, beat, rvalid, rdata, done, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/simd_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, else lowest overall.
module simd_rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic             valid
);

  // Two passes: indices >= ptr first, then wrap to the lowest remaining index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    gnt   = '0;
    valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        valid  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[i]) begin
        gnt[i] = 1'b1;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simd_mem_arbiter.sv
// Round-robin burst arbiter/sequencer for the shared single-port SIMD data memory.
// SIMD_MEM_ARB_HOST_EN (see package) enables the host port as a third requester.
module simd_mem_arbiter
  import simd_mem_pkg::*;
(
  input logic               CLK,
  input logic               RSTN,
  simd_mem_arbiter_if.slave bus
);

  state_e            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  pick_idx;
  logic [NREQ-1:0]   pick_oh;
  logic [NREQ-1:0]   win_oh;
  logic              pick_valid;
  logic              pick_we;
  logic              cur_we;
  logic              fin_ext;
  logic              rd_pipe;
  logic [ADDR_W-1:0] pick_addr;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  pick_len;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] pick_wdata;
  logic [DATA_W-1:0] win_wdata;

  simd_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .gnt   (pick_oh),
    .valid (pick_valid)
  );

  assign cnt_nxt = cnt + 1'b1;

  // One-hot muxes: candidate winner's request fields, and the live winner's write data.
  always_comb begin
    pick_idx   = '0;
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_len   = '0;
    pick_wdata = '0;
    win_wdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx   = PTR_W'(i);
        pick_we    = bus.we[i];
        pick_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        pick_len   = bus.len[i*LEN_W +: LEN_W];
        pick_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
      if (win_oh[i]) begin
        win_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state         <= S_IDLE;
      ptr           <= '0;
      cnt           <= '0;
      len_q         <= '0;
      base          <= '0;
      cur_we        <= 1'b0;
      win_oh        <= '0;
      fin_ext       <= 1'b0;
      rd_pipe       <= 1'b0;
      bus.gnt       <= '0;
      bus.beat      <= '0;
      bus.rvalid    <= '0;
      bus.rdata     <= '0;
      bus.done      <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      // Read return path: macro answers one cycle after MEM_EN, then one register stage.
      bus.done   <= '0;
      rd_pipe    <= bus.mem_en & ~bus.mem_we;
      bus.rvalid <= rd_pipe ? win_oh : '0;
      bus.rdata  <= bus.mem_rdata;

      unique case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state         <= S_BURST;
            ptr           <= ptr_after(pick_idx);
            cnt           <= '0;
            len_q         <= pick_len;
            base          <= pick_addr;
            cur_we        <= pick_we;
            win_oh        <= pick_oh;
            bus.gnt       <= pick_oh;
            bus.beat      <= pick_oh;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= pick_we;
            bus.mem_addr  <= pick_addr;
            bus.mem_wdata <= pick_wdata;
          end else begin
            bus.beat   <= '0;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
          end
        end

        S_BURST: begin
          if (cnt == len_q) begin
            state      <= S_FINISH;
            bus.gnt    <= '0;
            bus.beat   <= '0;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            // Reads hold FINISH one more cycle so DONE lands on the last RVALID.
            fin_ext    <= ~cur_we;
            if (cur_we) bus.done <= win_oh;
          end else begin
            cnt           <= cnt_nxt;
            bus.mem_addr  <= base + ADDR_W'(cnt_nxt);
            bus.mem_wdata <= win_wdata;
          end
        end

        S_FINISH: begin
          if (fin_ext) begin
            fin_ext  <= 1'b0;
            bus.done <= win_oh;
          end else begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_mem_arbiter.sv
// Directed self-checking bench for simd_mem_arbiter with a 1-cycle-latency memory model.
`timescale 1ns/1ps
module tb_simd_mem_arbiter;
  import simd_mem_pkg::*;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 CLK = ~CLK;

  simd_mem_arbiter_if bus ();

  simd_mem_arbiter dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  logic [DATA_W-1:0] mem [16];

  always @(posedge CLK) begin
    if (!RSTN) bus.mem_rdata <= '0;
    else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.len   = '0;
    bus.wdata = '0;
  endtask

  task automatic setup_req(input int r, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] d);
    bus.we[r]                     = w;
    bus.addr[r*ADDR_W +: ADDR_W]  = a;
    bus.len[r*LEN_W +: LEN_W]     = l;
    bus.wdata[r*DATA_W +: DATA_W] = d;
    bus.req[r]                    = 1'b1;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    clear_inputs();
    tick();
    tick();
    RSTN = 1'b1;
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    oh_idx = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) oh_idx = i;
  endfunction

  // Records the index of each new grant; requesters outside keep drop REQ on their DONE.
  task automatic collect_grants(input int n, input logic [NREQ-1:0] keep,
                                output int seq[6], output int at[6], output int got);
    logic [NREQ-1:0] prev;
    got  = 0;
    prev = bus.gnt;
    for (int i = 0; i < 6; i++) begin
      seq[i] = -1;
      at[i]  = -1;
    end
    for (int c = 0; c < 80 && got < n; c++) begin
      tick();
      if (bus.gnt != '0 && bus.gnt != prev) begin
        seq[got] = oh_idx(bus.gnt);
        at[got]  = c;
        got++;
      end
      prev    = bus.gnt;
      bus.req = bus.req & ~(bus.done & ~keep);
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 80 && !ok; c++) begin
      tick();
      bus.req = bus.req & ~bus.done;
      if (bus.req == '0) ok = 1'b1;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    clear_inputs();
    tick();
    tick();
    tick();
    n_checks++;
    if ({bus.gnt, bus.beat, bus.rvalid, bus.done} !== '0)
      $display("FAIL reset_strobes got=%b required=0", {bus.gnt, bus.beat, bus.rvalid, bus.done});
    else n_pass++;
    n_checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata} !== '0)
      $display("FAIL reset_mem got=%h required=0",
               {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata});
    else n_pass++;
    RSTN = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.mem_en !== 1'b0 || bus.gnt !== '0)
      $display("FAIL idle_no_req mem_en=%b gnt=%b required 0/0", bus.mem_en, bus.gnt);
    else n_pass++;
  endtask

  task automatic test_single_read();
    logic [DATA_W-1:0] rd_exp [4];
    logic [NREQ-1:0]   g_exp;
    logic [NREQ-1:0]   v_exp;
    logic [NREQ-1:0]   d_exp;
    rd_exp = '{8'hC3, 8'h44, 8'h95, 8'h06};
    mem[3] = 8'hC3;
    mem[4] = 8'h44;
    mem[5] = 8'h95;
    mem[6] = 8'h06;
    setup_req(REQ_LOAD, 1'b0, 4'h3, 4'd3, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      tick();
      g_exp = (k <= 4) ? NREQ'(1) : '0;
      v_exp = (k >= 3 && k <= 6) ? NREQ'(1) : '0;
      d_exp = (k == 6) ? NREQ'(1) : '0;
      n_checks++;
      if (bus.gnt !== g_exp || bus.mem_en !== (k <= 4))
        $display("FAIL read_gnt k=%0d gnt=%b mem_en=%b required %b/%b", k, bus.gnt, bus.mem_en, g_exp, k <= 4);
      else n_pass++;
      if (k <= 4) begin
        n_checks++;
        if (bus.mem_addr !== ADDR_W'(2 + k) || bus.mem_we !== 1'b0)
          $display("FAIL read_addr k=%0d addr=%h we=%b required %h/0", k, bus.mem_addr, bus.mem_we, 2 + k);
        else n_pass++;
      end
      n_checks++;
      if (bus.rvalid !== v_exp || bus.done !== d_exp)
        $display("FAIL read_rvalid_done k=%0d rvalid=%b done=%b required %b/%b", k, bus.rvalid, bus.done, v_exp, d_exp);
      else n_pass++;
      if (k >= 3 && k <= 6) begin
        n_checks++;
        if (bus.rdata !== rd_exp[k-3])
          $display("FAIL read_data k=%0d rdata=%h required %h", k, bus.rdata, rd_exp[k-3]);
        else n_pass++;
      end
      if (bus.done[REQ_LOAD]) bus.req[REQ_LOAD] = 1'b0;
    end
  endtask

  task automatic test_write_wrap();
    logic [DATA_W-1:0] wd [3];
    logic [ADDR_W-1:0] wa [3];
    logic [NREQ-1:0]   d_exp;
    wd = '{8'hA1, 8'hA2, 8'hA3};
    wa = '{4'hE, 4'hF, 4'h0};
    setup_req(REQ_STORE, 1'b1, 4'hE, 4'd2, 8'hA1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 3) begin
        n_checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== wa[k-1] ||
            bus.mem_wdata !== wd[k-1] || bus.beat !== NREQ'(2))
          $display("FAIL write_beat k=%0d en=%b we=%b addr=%h wdata=%h beat=%b required 1/1/%h/%h/%b",
                   k, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.beat, wa[k-1], wd[k-1], NREQ'(2));
        else n_pass++;
      end
      d_exp = (k == 4) ? NREQ'(2) : '0;
      n_checks++;
      if (bus.done !== d_exp)
        $display("FAIL write_done k=%0d done=%b required %b", k, bus.done, d_exp);
      else n_pass++;
      if (bus.beat[REQ_STORE])
        bus.wdata[REQ_STORE*DATA_W +: DATA_W] = bus.wdata[REQ_STORE*DATA_W +: DATA_W] + 8'h01;
      if (bus.done[REQ_STORE]) bus.req[REQ_STORE] = 1'b0;
    end
    n_checks++;
    if ({mem[14], mem[15], mem[0]} !== 24'hA1A2A3)
      $display("FAIL write_mem got=%h required a1a2a3", {mem[14], mem[15], mem[0]});
    else n_pass++;
  endtask

  task automatic test_contention();
    int seq [6];
    int at  [6];
    int got;
    bit ok;
    do_reset();
    for (int r = 0; r < NREQ; r++) setup_req(r, 1'b1, ADDR_W'(8 + r), 4'd0, DATA_W'(16 + r));
    collect_grants(NREQ, '0, seq, at, got);
    n_checks++;
    if (got !== NREQ) $display("FAIL contention_count got=%0d required %0d", got, NREQ);
    else n_pass++;
    for (int i = 0; i < NREQ; i++) begin
      n_checks++;
      if (seq[i] !== i) $display("FAIL contention_order pos=%0d got=%0d required %0d", i, seq[i], i);
      else n_pass++;
    end
    n_checks++;
    if (at[0] !== 0 || at[1] - at[0] !== 3)
      $display("FAIL contention_timing first=%0d gap=%0d required 0/3", at[0], at[1] - at[0]);
    else n_pass++;
    drain(ok);
    setup_req(REQ_LOAD, 1'b1, 4'h1, 4'd0, 8'h5A);
    setup_req(REQ_STORE, 1'b1, 4'h2, 4'd0, 8'h5B);
    collect_grants(2, '0, seq, at, got);
    n_checks++;
    if (got !== 2 || seq[0] !== 0 || seq[1] !== 1)
      $display("FAIL contention_wrap got=%0d seq=%0d,%0d required 2 grants 0,1", got, seq[0], seq[1]);
    else n_pass++;
    drain(ok);
    n_checks++;
    if (!ok) $display("FAIL contention_drain timed out required all DONE");
    else n_pass++;
  endtask

  task automatic test_fairness();
    int seq [6];
    int at  [6];
    int got;
    bit seen;
    setup_req(REQ_LOAD, 1'b1, 4'h1, 4'd1, 8'h55);
    tick();
    n_checks++;
    if (bus.gnt !== NREQ'(1)) $display("FAIL fair_first gnt=%b required %b", bus.gnt, NREQ'(1));
    else n_pass++;
    setup_req(REQ_STORE, 1'b1, 4'h9, 4'd1, 8'h66);
    collect_grants(2, NREQ'(1), seq, at, got);
    n_checks++;
    if (got !== 2 || seq[0] !== 1 || seq[1] !== 0)
      $display("FAIL fair_order got=%0d seq=%0d,%0d required 2 grants 1,0", got, seq[0], seq[1]);
    else n_pass++;
    // Requester 0 drops REQ in the first beat; the burst must still complete.
    bus.req[REQ_LOAD] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      tick();
      if (bus.done[REQ_LOAD]) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL fair_drop_done done=0 required DONE after dropped REQ");
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_max_burst();
    int beats;
    logic [ADDR_W-1:0] last_addr;
    bit seen;
    beats     = 0;
    last_addr = '0;
    seen      = 1'b0;
    setup_req(REQ_LOAD, 1'b1, 4'h5, 4'd15, 8'h00);
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      if (bus.beat[REQ_LOAD]) begin
        beats++;
        last_addr = bus.mem_addr;
      end
      if (bus.done[REQ_LOAD]) begin
        seen              = 1'b1;
        bus.req[REQ_LOAD] = 1'b0;
      end
    end
    n_checks++;
    if (beats !== 16 || last_addr !== 4'h4 || !seen)
      $display("FAIL max_burst beats=%0d last_addr=%h done=%b required 16/4/1", beats, last_addr, seen);
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int dones;
    do_reset();
    setup_req(REQ_LOAD, 1'b1, 4'h8, 4'd5, 8'h77);
    tick();
    tick();
    n_checks++;
    if (bus.mem_addr !== 4'h9 || bus.beat !== NREQ'(1))
      $display("FAIL abort_beat2 addr=%h beat=%b required 9/%b", bus.mem_addr, bus.beat, NREQ'(1));
    else n_pass++;
    RSTN    = 1'b0;
    bus.req = '0;
    tick();
    n_checks++;
    if ({bus.gnt, bus.beat, bus.rvalid, bus.done, bus.mem_en, bus.mem_we} !== '0)
      $display("FAIL abort_strobes got=%b required 0", {bus.gnt, bus.beat, bus.rvalid, bus.done, bus.mem_en, bus.mem_we});
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== '0)
      $display("FAIL abort_data got=%h required 0", {bus.mem_addr, bus.mem_wdata, bus.rdata});
    else n_pass++;
    setup_req(REQ_LOAD, 1'b1, 4'h2, 4'd0, 8'h21);
    setup_req(REQ_STORE, 1'b1, 4'h6, 4'd0, 8'h31);
    RSTN = 1'b1;
    tick();
    n_checks++;
    if (bus.gnt !== NREQ'(1) || bus.mem_addr !== 4'h2)
      $display("FAIL abort_regrant gnt=%b addr=%h required %b/2", bus.gnt, bus.mem_addr, NREQ'(1));
    else n_pass++;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.done[REQ_LOAD]) dones++;
      bus.req = bus.req & ~bus.done;
    end
    n_checks++;
    if (dones !== 1) $display("FAIL abort_done_count got=%0d required 1", dones);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    clear_inputs();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_single_read();
    test_write_wrap();
    test_contention();
    test_fairness();
    test_max_burst();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
